// File: rtl/mem_stage_unit_if.sv
// Data-bus interface for the MEMORY stage unit.
//   master : the stage unit (drives req/we/addr/wdata/wmask, receives rdata/ack)
//   slave  : the memory/bus side (drives rdata/ack)
// bus_ack completes a request in the cycle it is seen together with bus_req=1.
interface mem_stage_unit_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_wmask,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_stage_unit.sv
// MEMORY stage responder for the one-hot stage sequencer.
// Watches stage_active, performs one load/store over the req/ack data bus,
// then holds stage_done until the sequencer drops stage_active.
// Ports:
//   clk, reset              clock; synchronous active-high reset
//   stage_active/stage_done sequencer handshake (stage_done registered)
//   op_load/op_store/funct3 access kind and width/sign
//   addr/store_data         effective byte address, rs2 value
//   load_data               formatted load result, valid while stage_done=1
//   exc_misaligned/illegal/bus_timeout  exception flags, held with stage_done
//   bus                     data bus (master side of mem_stage_unit_if)
// TIMEOUT_CYCLES: bus_req cycles without ack before the access is aborted.
module mem_stage_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stage_active,
   output logic                     stage_done,
   input  logic                     op_load,
   input  logic                     op_store,
   input  logic [2:0]               funct3,
   input  logic [31:0]              addr,
   input  logic [31:0]              store_data,
   output logic [31:0]              load_data,
   output logic                     exc_misaligned,
   output logic                     exc_illegal,
   output logic                     exc_bus_timeout,
   mem_stage_unit_if.master         bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam int unsigned    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;

   // Access attributes captured at issue so formatting does not depend on
   // the inputs staying stable if the sequencer misbehaves mid-access.
   logic             acc_load;
   logic [2:0]       acc_f3;
   logic [1:0]       acc_off;

   logic             f3_illegal;
   logic             addr_misaligned;
   logic [31:0]      st_wdata;
   logic [3:0]       st_wmask;
   logic [31:0]      ld_fmt;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;

   // Request decode.
   always_comb begin
      f3_illegal      = 1'b0;
      addr_misaligned = 1'b0;
      if (op_load)
         f3_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
      else if (op_store)
         f3_illegal = (funct3 > 3'b010);
      if (funct3[1:0] == 2'b01)
         addr_misaligned = addr[0];
      else if (funct3[1:0] == 2'b10)
         addr_misaligned = (addr[1:0] != 2'b00);
   end

   // Store lane steering: data replicated into every lane, mask selects.
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            st_wdata = {4{store_data[7:0]}};
            st_wmask = 4'b0001 << addr[1:0];
         end
         2'b01: begin
            st_wdata = {2{store_data[15:0]}};
            st_wmask = 4'b0011 << addr[1:0];
         end
         default: begin
            st_wdata = store_data;
            st_wmask = 4'b1111;
         end
      endcase
   end

   // Load formatting from the captured width and byte offset.
   always_comb begin
      ld_byte = bus.bus_rdata[{acc_off, 3'b000} +: 8];
      ld_half = bus.bus_rdata[{acc_off[1], 4'b0000} +: 16];
      case (acc_f3)
         3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_fmt = {24'h000000, ld_byte};
         3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_fmt = {16'h0000, ld_half};
         default: ld_fmt = bus.bus_rdata;
      endcase
   end

   assign cnt_next = cnt + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= ST_IDLE;
         cnt             <= '0;
         acc_load        <= 1'b0;
         acc_f3          <= '0;
         acc_off         <= '0;
         stage_done      <= 1'b0;
         load_data       <= '0;
         exc_misaligned  <= 1'b0;
         exc_illegal     <= 1'b0;
         exc_bus_timeout <= 1'b0;
         bus.bus_req     <= 1'b0;
         bus.bus_we      <= 1'b0;
         bus.bus_addr    <= '0;
         bus.bus_wdata   <= '0;
         bus.bus_wmask   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (stage_active) begin
                  if (!(op_load || op_store)) begin
                     state      <= ST_DONE;
                     stage_done <= 1'b1;
                  end else if (f3_illegal) begin
                     // Illegal width takes precedence over misalignment.
                     exc_illegal <= 1'b1;
                     state       <= ST_DONE;
                     stage_done  <= 1'b1;
                  end else if (addr_misaligned) begin
                     exc_misaligned <= 1'b1;
                     state          <= ST_DONE;
                     stage_done     <= 1'b1;
                  end else begin
                     state         <= ST_BUS;
                     cnt           <= '0;
                     acc_load      <= op_load;
                     acc_f3        <= funct3;
                     acc_off       <= addr[1:0];
                     bus.bus_req   <= 1'b1;
                     bus.bus_we    <= op_store;
                     bus.bus_addr  <= {addr[31:2], 2'b00};
                     bus.bus_wdata <= op_store ? st_wdata : '0;
                     bus.bus_wmask <= op_store ? st_wmask : '0;
                  end
               end
            end

            ST_BUS: begin
               if (bus.bus_ack) begin
                  bus.bus_req   <= 1'b0;
                  bus.bus_wmask <= '0;
                  // If the sequencer already dropped stage_active, finish
                  // silently: no stage_done, nothing left latched.
                  if (stage_active) begin
                     load_data  <= acc_load ? ld_fmt : '0;
                     state      <= ST_DONE;
                     stage_done <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else if (cnt_next == CNT_LIMIT) begin
                  bus.bus_req   <= 1'b0;
                  bus.bus_wmask <= '0;
                  load_data     <= '0;
                  if (stage_active) begin
                     exc_bus_timeout <= 1'b1;
                     state           <= ST_DONE;
                     stage_done      <= 1'b1;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  cnt <= cnt_next;
               end
            end

            ST_DONE: begin
               if (!stage_active) begin
                  state           <= ST_IDLE;
                  stage_done      <= 1'b0;
                  load_data       <= '0;
                  exc_misaligned  <= 1'b0;
                  exc_illegal     <= 1'b0;
                  exc_bus_timeout <= 1'b0;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage_unit.sv
module tb_mem_stage_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        stage_active;
   logic        stage_done;
   logic        op_load;
   logic        op_store;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        exc_misaligned;
   logic        exc_illegal;
   logic        exc_bus_timeout;

   mem_stage_unit_if bus_if ();

   mem_stage_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk             (clk),
      .reset           (reset),
      .stage_active    (stage_active),
      .stage_done      (stage_done),
      .op_load         (op_load),
      .op_store        (op_store),
      .funct3          (funct3),
      .addr            (addr),
      .store_data      (store_data),
      .load_data       (load_data),
      .exc_misaligned  (exc_misaligned),
      .exc_illegal     (exc_illegal),
      .exc_bus_timeout (exc_bus_timeout),
      .bus             (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] ld;
      logic        mis;
      logic        ill;
      logic        to;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: on the first cycle the sequencer would accept stage_done,
   // pop the expected completion and compare.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (stage_active && stage_done && !prev_done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, ".load_data"}, load_data, e.ld);
            chk({e.name, ".exc_mis"}, {31'd0, exc_misaligned}, {31'd0, e.mis});
            chk({e.name, ".exc_ill"}, {31'd0, exc_illegal}, {31'd0, e.ill});
            chk({e.name, ".exc_to"}, {31'd0, exc_bus_timeout}, {31'd0, e.to});
         end
      end
      prev_done = stage_active && stage_done;
   end

   // ack_wait: number of no-ack bus_req cycles before ack (-1 = never ack).
   // e_req: expected number of cycles bus_req is high (0 = no bus access).
   task automatic run_op(input string nm, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd,
                         input int ack_wait, input logic [31:0] e_wdata,
                         input logic [3:0] e_wmask, input logic [31:0] e_ld,
                         input logic e_mis, input logic e_ill, input logic e_to,
                         input int e_req);
      exp_t e;
      int   req_cycles;
      e.name = nm; e.ld = e_ld; e.mis = e_mis; e.ill = e_ill; e.to = e_to;
      sb_q.push_back(e);
      stage_active = 1'b1;
      op_load = ld; op_store = st; funct3 = f3; addr = a; store_data = sd;
      chk({nm, ".done_c1"}, {31'd0, stage_done}, 32'd0);
      tick();
      if (e_req > 0) begin
         chk({nm, ".bus_we"}, {31'd0, bus_if.bus_we}, {31'd0, st});
         req_cycles = 0;
         for (int i = 0; i < 300; i++) begin
            if (!bus_if.bus_req) break;
            req_cycles++;
            chk({nm, ".bus_addr"}, bus_if.bus_addr, {a[31:2], 2'b00});
            chk({nm, ".bus_wdata"}, bus_if.bus_wdata, e_wdata);
            chk({nm, ".bus_wmask"}, {28'd0, bus_if.bus_wmask}, {28'd0, e_wmask});
            chk({nm, ".done_in_bus"}, {31'd0, stage_done}, 32'd0);
            if (ack_wait >= 0 && req_cycles == ack_wait + 1) begin
               bus_if.bus_ack   = 1'b1;
               bus_if.bus_rdata = rd;
            end
            tick();
            bus_if.bus_ack   = 1'b0;
            bus_if.bus_rdata = 32'h0;
         end
         chk({nm, ".req_cycles"}, req_cycles, e_req);
         chk({nm, ".wmask_after"}, {28'd0, bus_if.bus_wmask}, 32'd0);
      end else begin
         chk({nm, ".no_req"}, {31'd0, bus_if.bus_req}, 32'd0);
      end
      chk({nm, ".done_rise"}, {31'd0, stage_done}, 32'd1);
      tick();
      chk({nm, ".done_held"}, {31'd0, stage_done}, 32'd1);
      chk({nm, ".ld_held"}, load_data, e_ld);
      stage_active = 1'b0;
      op_load = 1'b0; op_store = 1'b0;
      tick();
      chk({nm, ".done_clr"}, {31'd0, stage_done}, 32'd0);
      chk({nm, ".exc_clr"}, {29'd0, exc_misaligned, exc_illegal, exc_bus_timeout}, 32'd0);
      chk({nm, ".ld_clr"}, load_data, 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      stage_active = 1'b0; op_load = 1'b0; op_store = 1'b0;
      funct3 = 3'b000; addr = 32'h0; store_data = 32'h0;
      bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
      tick(); tick(); tick();
      chk("rst.done", {31'd0, stage_done}, 32'd0);
      chk("rst.req", {31'd0, bus_if.bus_req}, 32'd0);
      chk("rst.we", {31'd0, bus_if.bus_we}, 32'd0);
      chk("rst.addr", bus_if.bus_addr, 32'd0);
      chk("rst.wdata", bus_if.bus_wdata, 32'd0);
      chk("rst.wmask", {28'd0, bus_if.bus_wmask}, 32'd0);
      chk("rst.ld", load_data, 32'd0);
      chk("rst.exc", {29'd0, exc_misaligned, exc_illegal, exc_bus_timeout}, 32'd0);
      reset = 1'b0;
      tick();

      //      name         ld st f3      addr          sd            rdata         aw  wdata         wmask    load_data     m  i  t  req
      run_op("noop",       0, 0, 3'b000, 32'h0000_0000, 32'h0,        32'h0,        0,  32'h0,        4'b0000, 32'h0,        0, 0, 0, 0);
      run_op("lb",         1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_1234, 2, 32'h0,        4'b0000, 32'hFFFF_FF80, 0, 0, 0, 3);
      run_op("sh",         0, 1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,        3, 32'hBEEF_BEEF, 4'b1100, 32'h0,        0, 0, 0, 4);
      run_op("lw_mis",     1, 0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0,  32'h0,        4'b0000, 32'h0,        1, 0, 0, 0);
      run_op("st_ill",     0, 1, 3'b100, 32'h0000_0000, 32'h1234_5678, 32'h0,        0,  32'h0,        4'b0000, 32'h0,        0, 1, 0, 0);
      run_op("lhu_to",     1, 0, 3'b101, 32'h0000_0010, 32'h0,        32'h0,        -1, 32'h0,        4'b0000, 32'h0,        0, 0, 1, TO);
      run_op("lh_fast",    1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 0, 32'h0,        4'b0000, 32'hFFFF_8001, 0, 0, 0, 1);
      run_op("lhu_lo",     1, 0, 3'b101, 32'h0000_0000, 32'h0,        32'h8001_8FFF, 0, 32'h0,        4'b0000, 32'h0000_8FFF, 0, 0, 0, 1);
      run_op("lbu",        1, 0, 3'b100, 32'h0000_1001, 32'h0,        32'h80FF_1234, 1, 32'h0,        4'b0000, 32'h0000_0012, 0, 0, 0, 2);
      run_op("lw",         1, 0, 3'b010, 32'h0000_0008, 32'h0,        32'h1234_5678, 0, 32'h0,        4'b0000, 32'h1234_5678, 0, 0, 0, 1);
      run_op("sb",         0, 1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 32'h0,        0, 32'hA5A5_A5A5, 4'b0010, 32'h0,        0, 0, 0, 1);
      run_op("sw",         0, 1, 3'b010, 32'h0000_4000, 32'hCAFE_F00D, 32'h0,        1, 32'hCAFE_F00D, 4'b1111, 32'h0,        0, 0, 0, 2);
      run_op("ld_ill",     1, 0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0,  32'h0,        4'b0000, 32'h0,        0, 1, 0, 0);
      run_op("ill_mis",    1, 0, 3'b111, 32'h0000_0001, 32'h0,        32'h0,        0,  32'h0,        4'b0000, 32'h0,        0, 1, 0, 0);
      run_op("sh_mis",     0, 1, 3'b001, 32'h0000_2001, 32'h1111_2222, 32'h0,        0,  32'h0,        4'b0000, 32'h0,        1, 0, 0, 0);

      // Reset while a request is outstanding.
      stage_active = 1'b1; op_load = 1'b1; funct3 = 3'b010; addr = 32'h0000_0020;
      tick();
      chk("rstbus.req_on", {31'd0, bus_if.bus_req}, 32'd1);
      tick();
      reset = 1'b1;
      tick();
      chk("rstbus.req_off", {31'd0, bus_if.bus_req}, 32'd0);
      chk("rstbus.done", {31'd0, stage_done}, 32'd0);
      chk("rstbus.addr", bus_if.bus_addr, 32'd0);
      reset = 1'b0;
      stage_active = 1'b0; op_load = 1'b0;
      tick();
      run_op("post_rst",   1, 0, 3'b000, 32'h0000_0001, 32'h0,        32'h0000_7F00, 0, 32'h0,        4'b0000, 32'h0000_007F, 0, 0, 0, 1);

      chk("sb_empty", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
